vga_pixel_scanner: RTL and testbench
====================================

Name: vga_pixel_scanner

Overview:
Raster timing source and final output stage of the VGA path. Generates the pixelX/pixelY scan coordinates consumed by every drawing object (square objects, bitmaps). Takes back the merged 8-bit RGB from the objects mux and drives registered hsync/vsync/blank and 4-4-4 colour to the DAC. Sync and blank are delayed to match the registered latency of the object pipeline.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BACK, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FRONT, 10, vertical front porch
V_SYNC, 2, vsync width
V_BACK, 33, vertical back porch
SYNC_ACTIVE, 1'b0, asserted level of hsync/vsync
PIPE_DELAY, 2, clk-enable periods from pixelX/Y to valid RGBin (range 1..4)

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous, active-low reset
pixEn  in  1  pixel-rate enable (e.g. 25 MHz tick on 50 MHz clk)
RGBin  in  8  merged object colour, 3-3-2 (R[7:5] G[4:2] B[1:0])
pixelX  out  11 signed  current horizontal count
pixelY  out  11 signed  current vertical count
startOfFrame  out  1  one-clk pulse at start of vertical blanking
hsync  out  1  horizontal sync, PIPE_DELAY-aligned
vsync  out  1  vertical sync, PIPE_DELAY-aligned
blankN  out  1  high during visible region, PIPE_DELAY-aligned
red  out  4  DAC red
green  out  4  DAC green
blue  out  4  DAC blue

Behaviour:
- Reset: hCount=vCount=0, pixelX=pixelY=0, startOfFrame=0, hsync=vsync=~SYNC_ACTIVE, blankN=0, red=green=blue=0, delay line cleared to the same inactive values. Asynchronous reset mid-line restarts at (0,0) on the first pixEn after release.
- All state advances only on clk edges with pixEn=1. With pixEn=0 every register holds, except startOfFrame, which drops to 0.
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525).
- hCount counts 0..H_TOTAL-1 and wraps to 0. vCount increments when hCount wraps; it wraps from V_TOTAL-1 to 0 on the same edge.
- pixelX=hCount and pixelY=vCount, zero-extended into the signed 11-bit outputs (always non-negative). They are not masked in blanking.
- Horizontal regions, decoded from hCount: ACTIVE [0,H_ACTIVE), FRONT, SYNC [H_ACTIVE+H_FRONT, +H_SYNC), BACK. Vertical regions are decoded the same way from vCount.
- Raw hs = SYNC_ACTIVE when in horizontal SYNC, else ~SYNC_ACTIVE. Raw vs follows the same rule vertically.
- Raw vis = hActive && vActive.
- hs/vs/vis pass through a PIPE_DELAY-deep shift register, advancing on pixEn, to produce hsync/vsync/blankN. This aligns them with the RGBin that corresponds to the same pixelX/pixelY.
- Colour, registered on pixEn:
  - if the delayed vis is 1: red={R,R[2]}, green={G,G[2]}, blue={B,B}
  - else 0,0,0
  - RGBin 8'hFF (transparent) is not special here; the mux resolves it.
- startOfFrame is 1 for exactly one clk, on the pixEn edge where the counters become hCount=0, vCount=V_ACTIVE. It occurs once per frame, giving game logic the full vertical blank to update positions.
- Simultaneous h-wrap and v-wrap at (H_TOTAL-1, V_TOTAL-1) go to (0,0) in one enable.

Optional Feature:
VGA_TEST_PATTERN_EN:
- Defined: RGBin is ignored. Colour comes from an internal generator of 8 vertical bars, each H_ACTIVE/8 wide, computed from the PIPE_DELAY-delayed hCount:
  - bar k, 3-bit index k: 3-3-2 value = {{3{k[2]}},{3{k[1]}},{2{k[0]}}}
  - bars therefore run black, blue, green, cyan, red, magenta, yellow, white
  - timing and blanking are unchanged.
- Undefined: RGBin passthrough as above. No generator logic is synthesised.

Decomposition:
- Package vga_pkg holds:
  - the 640x480@60 timing constants (H_/V_ defaults, H_TOTAL, V_TOTAL)
  - typedef coord_t (logic signed [10:0])
  - typedef rgb332_t (logic [7:0])
  - TRANSPARENT_ENCODING = 8'hFF, shared with the drawing objects.
- One sub-module: vga_sync_delay, a parameterised PIPE_DELAY-deep, enable-gated shift register for {hs,vs,vis} with a reset value input.

Test Plan:
- Reset, then 10 pixEn pulses -> pixelX 0..10 counting, pixelY=0, blankN low for the first PIPE_DELAY enables and then high, hsync=1, startOfFrame=0.
- Free run, pixEn every 2nd clk -> hsync low for exactly 96 enables, starting PIPE_DELAY enables after pixelX=656; line period 800 enables; vsync low for 2 lines (1600 enables) starting at line 490.
- Full frame -> startOfFrame pulses once per 420000 enables, one clk wide, coincident with pixelX=0, pixelY=480.
- RGBin held 8'hE3 -> visible output red=F, green=0, blue=F; at pixelX 640..799 or pixelY ≥480, red/green/blue=0 and blankN=0.
- RGBin = 8'h1C only when pixelX==0 (delayed by PIPE_DELAY) -> only the first visible output pixel of each line has green=F, i.e. alignment is correct.
- Assert resetN low at pixelX=300, pixelY=200, for 3 clks -> all outputs return to reset values immediately; after release, counting resumes from (0,0). Also hold pixEn low for 50 clks -> all outputs frozen.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : vga_pkg
// Description : 640x480@60 raster timing defaults and colour types shared by
//               the VGA scanner and the drawing objects.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package vga_pkg;

  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int H_FRONT_DEFAULT  = 16;
  localparam int H_SYNC_DEFAULT   = 96;
  localparam int H_BACK_DEFAULT   = 48;
  localparam int V_ACTIVE_DEFAULT = 480;
  localparam int V_FRONT_DEFAULT  = 10;
  localparam int V_SYNC_DEFAULT   = 2;
  localparam int V_BACK_DEFAULT   = 33;

  localparam int H_TOTAL = H_ACTIVE_DEFAULT + H_FRONT_DEFAULT + H_SYNC_DEFAULT + H_BACK_DEFAULT;
  localparam int V_TOTAL = V_ACTIVE_DEFAULT + V_FRONT_DEFAULT + V_SYNC_DEFAULT + V_BACK_DEFAULT;

  typedef logic signed [10:0] coord_t;
  typedef logic [7:0]         rgb332_t;

  localparam rgb332_t TRANSPARENT_ENCODING = 8'hFF;

  // 3-3-2 to 4-4-4: replicate MSBs so full-scale maps to full-scale
  function automatic logic [11:0] expand_332(input rgb332_t c);
    return {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_sync_delay.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : vga_sync_delay
// Description : Enable-gated DEPTH-stage shift register that realigns the raw
//               sync/visible flags with the object pipeline's colour output.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module vga_sync_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_rst_val,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= i_rst_val;
    end else if (i_en) begin
      r_stage[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_dout = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vga_pixel_scanner.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : vga_pixel_scanner
// Description : Raster counter and DAC output stage. Define VGA_TEST_PATTERN_EN
//               to replace RGBin with an internal 8-bar colour generator.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module vga_pixel_scanner
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE    = H_ACTIVE_DEFAULT,
  parameter int   H_FRONT     = H_FRONT_DEFAULT,
  parameter int   H_SYNC      = H_SYNC_DEFAULT,
  parameter int   H_BACK      = H_BACK_DEFAULT,
  parameter int   V_ACTIVE    = V_ACTIVE_DEFAULT,
  parameter int   V_FRONT     = V_FRONT_DEFAULT,
  parameter int   V_SYNC      = V_SYNC_DEFAULT,
  parameter int   V_BACK      = V_BACK_DEFAULT,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   PIPE_DELAY  = 2
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               pixEn,
  input  logic [7:0]         RGBin,
  output logic signed [10:0] pixelX,
  output logic signed [10:0] pixelY,
  output logic               startOfFrame,
  output logic               hsync,
  output logic               vsync,
  output logic               blankN,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue
);

  localparam logic [10:0] c_h_last   = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] c_v_last   = 11'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [10:0] c_h_active = 11'(H_ACTIVE);
  localparam logic [10:0] c_v_active = 11'(V_ACTIVE);
  localparam logic [10:0] c_hs_start = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] c_hs_end   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] c_vs_start = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] c_vs_end   = 11'(V_ACTIVE + V_FRONT + V_SYNC);
`ifdef VGA_TEST_PATTERN_EN
  localparam int          c_dly_w    = 14;
  localparam logic [10:0] c_bar_w    = 11'(H_ACTIVE / 8);
`else
  localparam int          c_dly_w    = 3;
`endif

  logic [10:0]        r_h_count;
  logic [10:0]        r_v_count;
  logic [10:0]        w_h_next;
  logic [10:0]        w_v_next;
  logic               r_sof;
  logic               w_hs;
  logic               w_vs;
  logic               w_vis;
  logic [c_dly_w-1:0] w_dly_in;
  logic [c_dly_w-1:0] w_dly_rst;
  logic [c_dly_w-1:0] w_dly_out;
  logic               w_dly_vis;
  rgb332_t            w_src;
  logic [11:0]        r_rgb;

  always_comb begin
    w_h_next = (r_h_count == c_h_last) ? '0 : r_h_count + 11'd1;
    w_v_next = r_v_count;
    if (r_h_count == c_h_last)
      w_v_next = (r_v_count == c_v_last) ? '0 : r_v_count + 11'd1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_h_count <= '0;
      r_v_count <= '0;
    end else if (pixEn) begin
      r_h_count <= w_h_next;
      r_v_count <= w_v_next;
    end
  end

  // Fires on the edge that enters the first blanking line, and only for that clk
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_sof <= 1'b0;
    else         r_sof <= pixEn && (w_h_next == '0) && (w_v_next == c_v_active);
  end

  always_comb begin
    w_hs  = (r_h_count >= c_hs_start && r_h_count < c_hs_end) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    w_vs  = (r_v_count >= c_vs_start && r_v_count < c_vs_end) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    w_vis = (r_h_count < c_h_active) && (r_v_count < c_v_active);
  end

`ifdef VGA_TEST_PATTERN_EN
  assign w_dly_in  = {r_h_count, w_hs, w_vs, w_vis};
  assign w_dly_rst = {11'd0, ~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0};
`else
  assign w_dly_in  = {w_hs, w_vs, w_vis};
  assign w_dly_rst = {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0};
`endif

  vga_sync_delay #(
    .DEPTH (PIPE_DELAY),
    .WIDTH (c_dly_w)
  ) u_sync_delay (
    .clk       (clk),
    .resetN    (resetN),
    .i_en      (pixEn),
    .i_rst_val (w_dly_rst),
    .i_din     (w_dly_in),
    .o_dout    (w_dly_out)
  );

  assign hsync     = w_dly_out[2];
  assign vsync     = w_dly_out[1];
  assign w_dly_vis = w_dly_out[0];
  assign blankN    = w_dly_vis;

`ifdef VGA_TEST_PATTERN_EN
  logic [10:0] w_bar_idx;
  logic [2:0]  w_bar;
  assign w_bar_idx = w_dly_out[13:3] / c_bar_w;
  assign w_bar     = w_bar_idx[2:0];
  assign w_src     = {{3{w_bar[2]}}, {3{w_bar[1]}}, {2{w_bar[0]}}};
`else
  assign w_src = RGBin;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)    r_rgb <= '0;
    else if (pixEn) r_rgb <= w_dly_vis ? expand_332(w_src) : 12'd0;
  end

  assign red          = r_rgb[11:8];
  assign green        = r_rgb[7:4];
  assign blue         = r_rgb[3:0];
  assign pixelX       = $signed(r_h_count);
  assign pixelY       = $signed(r_v_count);
  assign startOfFrame = r_sof;

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_scanner.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_vga_pixel_scanner
// Description : Bench for vga_pixel_scanner: one default-timing instance and
//               one reduced-timing instance compared against a raster model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_vga_pixel_scanner;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, d;
  } geo_t;

  geo_t gd = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
  geo_t gs = '{16, 2, 4, 3, 6, 1, 2, 2, 3};

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic pixEn = 1'b0;
  logic [7:0] rgb_d, rgb_s;
  int mode = 0;

  logic signed [10:0] px_d, py_d, px_s, py_s;
  logic sof_d, hs_d, vs_d, bn_d, sof_s, hs_s, vs_s, bn_s;
  logic [3:0] r_d, g_d, b_d, r_s, g_s, b_s;

  int checks = 0;
  int errors = 0;
  int n = 0;
  bit en_last = 1'b0;
  bit run_chk = 1'b0;
  logic [7:0] last_d = 8'h00;
  logic [7:0] last_s = 8'h00;
  int sof_cnt = 0;
  int g_cnt = 0;

  always #5 clk = ~clk;

  vga_pixel_scanner dut (
    .clk(clk), .resetN(resetN), .pixEn(pixEn), .RGBin(rgb_d),
    .pixelX(px_d), .pixelY(py_d), .startOfFrame(sof_d),
    .hsync(hs_d), .vsync(vs_d), .blankN(bn_d),
    .red(r_d), .green(g_d), .blue(b_d)
  );

  vga_pixel_scanner #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .SYNC_ACTIVE(1'b0), .PIPE_DELAY(3)
  ) dut_s (
    .clk(clk), .resetN(resetN), .pixEn(pixEn), .RGBin(rgb_s),
    .pixelX(px_s), .pixelY(py_s), .startOfFrame(sof_s),
    .hsync(hs_s), .vsync(vs_s), .blankN(bn_s),
    .red(r_s), .green(g_s), .blue(b_s)
  );

  // ---------------- raster model: position k = enables since reset ----------
  function automatic int htot(geo_t g); return g.ha + g.hf + g.hs + g.hb; endfunction
  function automatic int frame_of(geo_t g); return htot(g) * (g.va + g.vf + g.vs + g.vb); endfunction
  function automatic int hx(geo_t g, int k); return (k % frame_of(g)) % htot(g); endfunction
  function automatic int vy(geo_t g, int k); return (k % frame_of(g)) / htot(g); endfunction
  function automatic bit vis_at(geo_t g, int k); return hx(g, k) < g.ha && vy(g, k) < g.va; endfunction
  function automatic bit hs_at(geo_t g, int k);
    return !(hx(g, k) >= g.ha + g.hf && hx(g, k) < g.ha + g.hf + g.hs);
  endfunction
  function automatic bit vs_at(geo_t g, int k);
    return !(vy(g, k) >= g.va + g.vf && vy(g, k) < g.va + g.vf + g.vs);
  endfunction

  function automatic logic [11:0] expand(logic [7:0] c);
    int r, gg, b;
    r  = c / 32;
    gg = (c / 4) % 8;
    b  = c % 4;
    return 12'((r * 2 + r / 4) * 256 + (gg * 2 + gg / 4) * 16 + b * 5);
  endfunction

  function automatic logic [7:0] stim(int m, geo_t g, int k);
    if (k < 0) return 8'h00;
    case (m)
      0:       return 8'hE3;
      1:       return (hx(g, k) == 0) ? 8'h1C : 8'h00;
      default: return 8'((hx(g, k) * 37 + vy(g, k) * 11 + 5) % 256);
    endcase
  endfunction

  function automatic logic [11:0] exp_col(geo_t g, int nn, logic [7:0] last);
    int k;
    k = nn - g.d - 1;
    if (k < 0 || !vis_at(g, k)) return 12'h000;
`ifdef VGA_TEST_PATTERN_EN
    begin
      int bar;
      logic [7:0] c;
      bar = hx(g, k) / (g.ha / 8);
      c = ((bar / 4) % 2 ? 8'hE0 : 8'h00) | ((bar / 2) % 2 ? 8'h1C : 8'h00) | (bar % 2 ? 8'h03 : 8'h00);
      return expand(c);
    end
`else
    return expand(last);
`endif
  endfunction

  always_comb begin
    rgb_d = stim(mode, gd, n - gd.d);
    rgb_s = stim(mode, gs, n - gs.d);
  end

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      n       <= 0;
      en_last <= 1'b0;
    end else begin
      en_last <= pixEn;
      if (pixEn) begin
        n      <= n + 1;
        last_d <= rgb_d;
        last_s <= rgb_s;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input geo_t g, input logic [7:0] last,
                     input logic [10:0] px, input logic [10:0] py,
                     input logic hs, input logic vs, input logic bn,
                     input logic sof, input logic [11:0] col);
    chk({tag, ".pixelX"}, 32'(px), 32'(hx(g, n)));
    chk({tag, ".pixelY"}, 32'(py), 32'(vy(g, n)));
    chk({tag, ".hsync"},  32'(hs), 32'((n >= g.d) ? hs_at(g, n - g.d) : 1'b1));
    chk({tag, ".vsync"},  32'(vs), 32'((n >= g.d) ? vs_at(g, n - g.d) : 1'b1));
    chk({tag, ".blankN"}, 32'(bn), 32'((n >= g.d) ? vis_at(g, n - g.d) : 1'b0));
    chk({tag, ".rgb"},    32'(col), 32'(exp_col(g, n, last)));
    chk({tag, ".sof"},    32'(sof), 32'(en_last && (n % frame_of(g) == g.va * htot(g))));
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      cmp("dflt", gd, last_d, px_d, py_d, hs_d, vs_d, bn_d, sof_d, {r_d, g_d, b_d});
      cmp("small", gs, last_s, px_s, py_s, hs_s, vs_s, bn_s, sof_s, {r_s, g_s, b_s});
    end
  end

  task automatic step(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      sof_cnt += int'(sof_s);
      pixEn = 1'b1;
      @(negedge clk);
      sof_cnt += int'(sof_s);
      if (g_d == 4'hF) g_cnt++;
      pixEn = 1'b0;
    end
  endtask

  // ---------------- directed sequence with hand-computed literals ----------
  initial begin
    repeat (3) @(negedge clk);
    run_chk = 1'b1;
    @(negedge clk);
    chk("rst.pixelX", 32'(px_d), 0);
    chk("rst.hsync", 32'(hs_d), 1);
    chk("rst.vsync", 32'(vs_d), 1);
    chk("rst.blankN", 32'(bn_d), 0);
    chk("rst.red", 32'(r_d), 0);
    chk("rst.sof", 32'(sof_d), 0);
    resetN = 1'b1;

    step(10);
    chk("n10.pixelX", 32'(px_d), 10);
    chk("n10.pixelY", 32'(py_d), 0);
    chk("n10.blankN", 32'(bn_d), 1);
    chk("n10.rgb", 32'({r_d, g_d, b_d}), 32'h00F0F);

    step(647);
    chk("hs.before", 32'(hs_d), 1);
    step(1);
    chk("hs.first", 32'(hs_d), 0);
    step(95);
    chk("hs.last", 32'(hs_d), 0);
    step(1);
    chk("hs.after", 32'(hs_d), 1);
    chk("hblank.blankN", 32'(bn_d), 0);
    chk("hblank.red", 32'(r_d), 0);
    step(46);
    chk("line.pixelX", 32'(px_d), 0);
    chk("line.pixelY", 32'(py_d), 1);

    mode = 1;
    g_cnt = 0;
    step(800);
    chk("align.green_count", 32'(g_cnt), 1);

    mode = 2;
    step(135);
    chk("pre_rst.pixelX_s", 32'(px_s), 10);
    chk("pre_rst.pixelY_s", 32'(py_s), 3);
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    chk("arst.pixelX_s", 32'(px_s), 0);
    chk("arst.pixelY_s", 32'(py_s), 0);
    chk("arst.hsync_s", 32'(hs_s), 1);
    chk("arst.blankN_s", 32'(bn_s), 0);
    chk("arst.pixelX_d", 32'(px_d), 0);
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    step(1);
    chk("restart.pixelX_s", 32'(px_s), 1);
    chk("restart.pixelX_d", 32'(px_d), 1);

    sof_cnt = 0;
    step(825);
    chk("frames.sof_count", 32'(sof_cnt), 3);

    repeat (50) @(negedge clk);
    chk("freeze.pixelX_s", 32'(px_s), 1);
    chk("freeze.pixelX_d", 32'(px_d), 26);
    chk("freeze.pixelY_d", 32'(py_d), 1);

    @(negedge clk);
    pixEn = 1'b1;
    repeat (600) @(negedge clk);
    pixEn = 1'b0;
    repeat (4) @(negedge clk);

    run_chk = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
